// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the arbiter, the pipeline-side requesters and the shared memory bus.
// The master modport is the arbiter's view; slave is the requesters/memory side.
interface mem_bus_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;

   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   logic        pc_we;
   logic        ifid_we;
   logic        ifid_clr;
   logic        idex_we;
   logic        exmem_we;
   logic        memwb_clr;

   modport master (
      input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_be, bus_ack, bus_rdata,
      output if_rdata, mem_rdata, bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err,
      output pc_we, ifid_we, ifid_clr, idex_we, exmem_we, memwb_clr
   );

   modport slave (
      output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, mem_be, bus_ack, bus_rdata,
      input  if_rdata, mem_rdata, bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err,
      input  pc_we, ifid_we, ifid_clr, idex_we, exmem_we, memwb_clr
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction fetch and data access onto one single-port memory bus and derives
// the pipeline stall/flush controls. Data accesses win over fetches; accesses are never preempted.
module mem_bus_arbiter (
   input  logic               clk,
   input  logic               rst,
   mem_bus_arbiter_if.master  port
);

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIfBusy  = 2'd1,
      StMemBusy = 2'd2
   } stateT;

   stateT       stateQ, stateD;
   logic [7:0]  cntQ, cntD;
   logic        busReqQ, busReqD;
   logic        busWeQ, busWeD;
   logic [31:0] busAddrQ, busAddrD;
   logic [31:0] busWdataQ, busWdataD;
   logic [3:0]  busBeQ, busBeD;
   logic [31:0] ifBufQ, ifBufD;
   logic        ifHoldQ, ifHoldD;
   logic        busErrQ, busErrD;

   logic        busy;
   logic        done;
   logic        timeout;
   logic        memDone;
   logic        ifDone;
   logic        memReq;
   logic        memStall;
   logic        ifStall;
   logic [31:0] ackData;

   logic        pcWe;
   logic        ifidWe;
   logic        ifidClr;
   logic        idexWe;
   logic        exmemWe;
   logic        memwbClr;

   // An access completes on ack, or is forced complete once the wait counter saturates.
   always_comb begin
      busy     = (stateQ != StIdle);
      timeout  = busy & ~port.bus_ack & (cntQ == 8'hFF);
      done     = busy & (port.bus_ack | (cntQ == 8'hFF));
      ackData  = port.bus_ack ? port.bus_rdata : 32'h0;
      memDone  = (stateQ == StMemBusy) & done;
      ifDone   = (stateQ == StIfBusy) & done;
      memReq   = port.mem_rd | port.mem_wr;
      memStall = memReq & ~memDone;
      ifStall  = port.if_req & ~ifHoldQ & ~ifDone;
   end

   always_comb begin
      pcWe     = 1'b1;
      ifidWe   = 1'b1;
      ifidClr  = 1'b0;
      idexWe   = 1'b1;
      exmemWe  = 1'b1;
      memwbClr = 1'b0;
      if (!rst) begin
         pcWe     = 1'b0;
         ifidWe   = 1'b0;
         ifidClr  = 1'b1;
         idexWe   = 1'b0;
         exmemWe  = 1'b0;
         memwbClr = 1'b1;
      end else if (memStall) begin
         pcWe     = 1'b0;
         ifidWe   = 1'b0;
         idexWe   = 1'b0;
         exmemWe  = 1'b0;
         memwbClr = 1'b1;
      end else if (ifStall) begin
         pcWe    = 1'b0;
         ifidClr = 1'b1;
      end
   end

   always_comb begin
      stateD    = stateQ;
      cntD      = cntQ;
      busReqD   = busReqQ;
      busWeD    = busWeQ;
      busAddrD  = busAddrQ;
      busWdataD = busWdataQ;
      busBeD    = busBeQ;
      ifBufD    = ifBufQ;
      ifHoldD   = ifHoldQ;
      busErrD   = timeout;

      unique case (stateQ)
         StIdle: begin
            if (memReq) begin
               stateD    = StMemBusy;
               cntD      = 8'h0;
               busReqD   = 1'b1;
               busWeD    = port.mem_wr;
               busAddrD  = port.mem_addr;
               busWdataD = port.mem_wdata;
               busBeD    = port.mem_be;
            end else if (port.if_req && !ifHoldQ) begin
               stateD    = StIfBusy;
               cntD      = 8'h0;
               busReqD   = 1'b1;
               busWeD    = 1'b0;
               busAddrD  = port.if_addr;
               busWdataD = 32'h0;
               busBeD    = 4'hF;
            end
         end
         StIfBusy, StMemBusy: begin
            if (done) begin
               stateD    = StIdle;
               busReqD   = 1'b0;
               busWeD    = 1'b0;
               busAddrD  = 32'h0;
               busWdataD = 32'h0;
               busBeD    = 4'h0;
            end else begin
               cntD = cntQ + 8'd1;
            end
         end
         default: stateD = StIdle;
      endcase

      // A fetched word stays held until IF/ID actually loads it without a data stall.
      if (ifDone) begin
         ifBufD  = ackData;
         ifHoldD = ~(ifidWe & ~memStall);
      end else if (ifidWe && !memStall) begin
         ifHoldD = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         stateQ    <= StIdle;
         cntQ      <= 8'h0;
         busReqQ   <= 1'b0;
         busWeQ    <= 1'b0;
         busAddrQ  <= 32'h0;
         busWdataQ <= 32'h0;
         busBeQ    <= 4'h0;
         ifBufQ    <= 32'h0;
         ifHoldQ   <= 1'b0;
         busErrQ   <= 1'b0;
      end else begin
         stateQ    <= stateD;
         cntQ      <= cntD;
         busReqQ   <= busReqD;
         busWeQ    <= busWeD;
         busAddrQ  <= busAddrD;
         busWdataQ <= busWdataD;
         busBeQ    <= busBeD;
         ifBufQ    <= ifBufD;
         ifHoldQ   <= ifHoldD;
         busErrQ   <= busErrD;
      end
   end

   assign port.bus_req   = busReqQ;
   assign port.bus_we    = busWeQ;
   assign port.bus_addr  = busAddrQ;
   assign port.bus_wdata = busWdataQ;
   assign port.bus_be    = busBeQ;
   assign port.bus_err   = busErrQ;
   assign port.mem_rdata = memDone ? ackData : 32'h0;
   assign port.if_rdata  = ifDone ? ackData : ifBufQ;
   assign port.pc_we     = pcWe;
   assign port.ifid_we   = ifidWe;
   assign port.ifid_clr  = ifidClr;
   assign port.idex_we   = idexWe;
   assign port.exmem_we  = exmemWe;
   assign port.memwb_clr = memwbClr;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model of the arbiter kept here.
module tb_mem_bus_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_bus_arbiter_if bus_if ();

   mem_bus_arbiter dut (
      .clk  (clk),
      .rst  (rst),
      .port (bus_if)
   );

   int tests = 0;
   int fails = 0;

   // Model: which access is in flight (0 none, 1 fetch, 2 data) and how long it has waited.
   int          mKind;
   int          mWait;
   logic [31:0] mAddr, mWdata, mBuf;
   logic        mWe, mHold, mErr;
   logic [3:0]  mBe;

   logic        eDone, eTimeout, eMemStall, eIfidWe;
   logic [31:0] eData;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Combinational expectations for the current cycle, sampled mid-cycle.
   task automatic settle();
      logic       busy, memDone, ifDone, ifStall;
      logic [5:0] ctrl, obs;
      @(negedge clk);
      busy      = (mKind != 0);
      eDone     = busy && (bus_if.bus_ack || mWait == 255);
      eTimeout  = eDone && !bus_if.bus_ack;
      eData     = bus_if.bus_ack ? bus_if.bus_rdata : 32'h0;
      memDone   = (mKind == 2) && eDone;
      ifDone    = (mKind == 1) && eDone;
      eMemStall = (bus_if.mem_rd || bus_if.mem_wr) && !memDone;
      ifStall   = bus_if.if_req && !mHold && !ifDone;
      // {pc_we, ifid_we, ifid_clr, idex_we, exmem_we, memwb_clr}
      if (!rst)           ctrl = 6'b001001;
      else if (eMemStall) ctrl = 6'b000001;
      else if (ifStall)   ctrl = 6'b011110;
      else                ctrl = 6'b110110;
      eIfidWe = ctrl[4];
      obs = {bus_if.pc_we, bus_if.ifid_we, bus_if.ifid_clr, bus_if.idex_we, bus_if.exmem_we,
             bus_if.memwb_clr};
      chk("pipe_ctrl", {26'h0, obs}, {26'h0, ctrl});
      chk("bus_req", {31'h0, bus_if.bus_req}, {31'h0, busy});
      if (busy) begin
         chk("bus_addr", bus_if.bus_addr, mAddr);
         chk("bus_we", {31'h0, bus_if.bus_we}, {31'h0, mWe});
         chk("bus_be", {28'h0, bus_if.bus_be}, {28'h0, mBe});
         if (mKind == 2) chk("bus_wdata", bus_if.bus_wdata, mWdata);
      end
      chk("mem_rdata", bus_if.mem_rdata, memDone ? eData : 32'h0);
      if (ifDone)     chk("if_rdata_ack", bus_if.if_rdata, eData);
      else if (mHold) chk("if_rdata_buf", bus_if.if_rdata, mBuf);
      chk("bus_err", {31'h0, bus_if.bus_err}, {31'h0, mErr});
   endtask

   task automatic advance();
      logic consumed, holdOld;
      @(posedge clk);
      if (!rst) begin
         mKind = 0; mWait = 0; mHold = 1'b0; mBuf = 32'h0; mErr = 1'b0;
      end else begin
         holdOld  = mHold;
         consumed = eIfidWe && !eMemStall;
         mErr     = eTimeout;
         if (mKind == 1 && eDone) begin
            mBuf  = eData;
            mHold = !consumed;
         end else if (consumed) begin
            mHold = 1'b0;
         end
         if (mKind != 0) begin
            if (eDone) mKind = 0;
            else       mWait++;
         end else if (bus_if.mem_rd || bus_if.mem_wr) begin
            mKind = 2; mWait = 0; mAddr = bus_if.mem_addr; mWe = bus_if.mem_wr;
            mWdata = bus_if.mem_wdata; mBe = bus_if.mem_be;
         end else if (bus_if.if_req && !holdOld) begin
            mKind = 1; mWait = 0; mAddr = bus_if.if_addr; mWe = 1'b0; mBe = 4'hF;
         end
      end
      #1;
   endtask

   task automatic tick();
      settle();
      advance();
   endtask

   initial begin
      int r;
      rst = 1'b0;
      bus_if.if_req = 1'b0; bus_if.if_addr = 32'h0;
      bus_if.mem_rd = 1'b0; bus_if.mem_wr = 1'b0; bus_if.mem_addr = 32'h0;
      bus_if.mem_wdata = 32'h0; bus_if.mem_be = 4'h0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      mKind = 0; mWait = 0; mAddr = 0; mWdata = 0; mBuf = 0; mWe = 0; mHold = 0; mErr = 0;
      mBe = 0; eDone = 0; eTimeout = 0; eMemStall = 0; eIfidWe = 0; eData = 0;
      advance();

      // Reset values
      settle();
      chk("rst_bus_we", {31'h0, bus_if.bus_we}, 32'h0);
      chk("rst_bus_addr", bus_if.bus_addr, 32'h0);
      chk("rst_bus_wdata", bus_if.bus_wdata, 32'h0);
      chk("rst_bus_be", {28'h0, bus_if.bus_be}, 32'h0);
      advance();
      rst = 1'b1;
      tick();

      // Fetch only, ack two cycles after bus_req
      bus_if.if_req = 1'b1; bus_if.if_addr = 32'h100;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("fetch_pc_we_stall", {31'h0, bus_if.pc_we}, 32'h0);
         chk("fetch_ifid_clr", {31'h0, bus_if.ifid_clr}, 32'h1);
         advance();
      end
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h24020001;
      settle();
      chk("fetch_if_rdata", bus_if.if_rdata, 32'h24020001);
      chk("fetch_pc_we_ack", {31'h0, bus_if.pc_we}, 32'h1);
      advance();
      bus_if.if_req = 1'b0; bus_if.bus_ack = 1'b0;
      tick();

      // Simultaneous load and fetch: load first
      bus_if.if_req = 1'b1; bus_if.if_addr = 32'h104;
      bus_if.mem_rd = 1'b1; bus_if.mem_addr = 32'h200;
      tick();
      settle();
      chk("sim_bus_addr", bus_if.bus_addr, 32'h200);
      chk("sim_memwb_clr", {31'h0, bus_if.memwb_clr}, 32'h1);
      chk("sim_exmem_we", {31'h0, bus_if.exmem_we}, 32'h0);
      advance();
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h00000055;
      settle();
      chk("sim_mem_rdata", bus_if.mem_rdata, 32'h55);
      advance();
      bus_if.mem_rd = 1'b0; bus_if.bus_ack = 1'b0;
      tick();
      settle();
      chk("sim_then_fetch", bus_if.bus_addr, 32'h104);
      advance();
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = $urandom;
      tick();
      bus_if.if_req = 1'b0; bus_if.bus_ack = 1'b0;
      tick();

      // Store held until ack
      bus_if.mem_wr = 1'b1; bus_if.mem_be = 4'b0011; bus_if.mem_wdata = 32'hABCD;
      bus_if.mem_addr = 32'h300;
      tick();
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("st_bus_we", {31'h0, bus_if.bus_we}, 32'h1);
         chk("st_bus_be", {28'h0, bus_if.bus_be}, 32'h3);
         chk("st_bus_wdata", bus_if.bus_wdata, 32'hABCD);
         advance();
      end
      bus_if.bus_ack = 1'b1;
      settle();
      chk("st_exmem_we_ack", {31'h0, bus_if.exmem_we}, 32'h1);
      advance();
      bus_if.mem_wr = 1'b0; bus_if.bus_ack = 1'b0;
      tick();

      // Fetch completes while a load waits: word held, no refetch
      bus_if.if_req = 1'b1; bus_if.if_addr = 32'h108;
      tick();
      bus_if.mem_rd = 1'b1; bus_if.mem_addr = 32'h400;
      tick();
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h11112222;
      tick();
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      settle();
      chk("hold_idle_rdata", bus_if.if_rdata, 32'h11112222);
      advance();
      for (int i = 0; i < 2; i++) begin
         settle();
         chk("hold_load_rdata", bus_if.if_rdata, 32'h11112222);
         chk("hold_load_addr", bus_if.bus_addr, 32'h400);
         advance();
      end
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h33;
      settle();
      chk("hold_load_done", bus_if.mem_rdata, 32'h33);
      advance();
      bus_if.mem_rd = 1'b0; bus_if.bus_ack = 1'b0; bus_if.if_addr = 32'h10C;
      tick();
      settle();
      chk("hold_next_fetch", bus_if.bus_addr, 32'h10C);
      advance();
      bus_if.bus_ack = 1'b1;
      tick();
      bus_if.if_req = 1'b0; bus_if.bus_ack = 1'b0;
      tick();

      // Load timeout
      bus_if.mem_rd = 1'b1; bus_if.mem_addr = 32'h500; bus_if.bus_rdata = 32'hDEAD;
      tick();
      for (int i = 0; i < 255; i++) tick();
      settle();
      chk("to_mem_rdata", bus_if.mem_rdata, 32'h0);
      chk("to_exmem_we", {31'h0, bus_if.exmem_we}, 32'h1);
      advance();
      bus_if.mem_rd = 1'b0;
      settle();
      chk("to_bus_err", {31'h0, bus_if.bus_err}, 32'h1);
      chk("to_idle", {31'h0, bus_if.bus_req}, 32'h0);
      advance();
      settle();
      chk("to_err_pulse", {31'h0, bus_if.bus_err}, 32'h0);
      advance();

      // Reset during a fetch
      bus_if.if_req = 1'b1; bus_if.if_addr = 32'h600;
      tick();
      tick();
      rst = 1'b0;
      tick();
      settle();
      chk("rst_mid_bus_req", {31'h0, bus_if.bus_req}, 32'h0);
      chk("rst_mid_pc_we", {31'h0, bus_if.pc_we}, 32'h0);
      chk("rst_mid_bus_err", {31'h0, bus_if.bus_err}, 32'h0);
      advance();
      rst = 1'b1; bus_if.if_req = 1'b0;
      tick();
      settle();
      chk("rst_mid_no_err", {31'h0, bus_if.bus_err}, 32'h0);
      advance();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 149) != 0);
         bus_if.if_req = $urandom_range(0, 1) == 1;
         bus_if.if_addr = $urandom;
         r = $urandom_range(0, 7);
         bus_if.mem_rd = (r == 0);
         bus_if.mem_wr = (r == 1);
         bus_if.mem_addr = $urandom;
         bus_if.mem_wdata = $urandom;
         bus_if.mem_be = 4'($urandom_range(0, 15));
         bus_if.bus_ack = $urandom_range(0, 2) == 0;
         bus_if.bus_rdata = $urandom;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, reset; it is synchronous and active-low.
REQ-003 SHALL have port if_req, input, 1, fetch request for if_addr.
REQ-004 SHALL have port if_addr, input, 32, fetch address.
REQ-005 SHALL have port if_rdata, output, 32, fetched word.
REQ-006 SHALL have ports mem_rd and mem_wr, input, 1 each, load/store request from the EX/MEM register outputs.
REQ-007 SHALL have ports mem_addr and mem_wdata, input, 32 each, plus mem_be, input, 4, the data access.
REQ-008 SHALL have port mem_rdata, output, 32, load data to MEM/WB.
REQ-009 SHALL have ports bus_req, bus_we, output, 1 each; bus_addr and bus_wdata, output, 32 each; bus_be, output, 4; the shared single-port bus.
REQ-010 SHALL have ports bus_ack, input, 1, and bus_rdata, input, 32, bus completion and read data.
REQ-011 SHALL have ports pc_we, ifid_we, ifid_clr, idex_we, exmem_we and memwb_clr, output, 1 each, pipeline-register controls.
REQ-012 SHALL have port bus_err, output, 1, one-cycle timeout pulse.

Function
REQ-013 SHALL implement the FSM states IDLE, IF_BUSY and MEM_BUSY.
REQ-014 In IDLE, if mem_rd|mem_wr is high, SHALL enter MEM_BUSY; otherwise, if if_req is high and if_hold is 0, SHALL enter IF_BUSY; otherwise it SHALL stay in IDLE. A data request has priority over a fetch.
REQ-015 On entry to a BUSY state, SHALL register the bus controls:
- bus_req = 1
- bus_addr
- bus_we = mem_wr in MEM_BUSY, 0 in IF_BUSY
- bus_wdata and bus_be = mem_be in MEM_BUSY, 4'hF in IF_BUSY
These SHALL be held stable until completion.
REQ-016 A BUSY state SHALL NOT be preempted; a data request arriving during IF_BUSY waits for IF_BUSY to complete.
REQ-017 Completion is bus_ack=1 in a BUSY state. On completion the FSM SHALL return to IDLE and bus_req SHALL be 0 the next cycle. Minimum latency is request seen at cycle N, bus_req at N+1, earliest ack at N+1.
REQ-018 SHALL run an 8-bit wait counter in BUSY states, cleared on entry. If the count reaches 255 without bus_ack, SHALL treat the access as completed with rdata=0 and pulse bus_err for 1 cycle.
REQ-019 mem_rdata SHALL equal bus_rdata (0 on timeout) in the MEM_BUSY completion cycle, and 0 otherwise.
REQ-020 An IF completion SHALL load if_buf from bus_rdata and set if_hold=1. if_rdata SHALL be bus_rdata in the completion cycle and if_buf while if_hold=1. if_hold SHALL clear on a cycle with ifid_we=1 and mem_stall=0.
REQ-021 mem_stall SHALL be (mem_rd|mem_wr) & ~(MEM_BUSY & completion). if_stall SHALL be if_req & ~if_hold & ~(IF_BUSY & completion). Both are combinational.
REQ-022 When mem_stall=1: pc_we=ifid_we=idex_we=exmem_we=0, ifid_clr=0, memwb_clr=1.
REQ-023 When mem_stall=0 and if_stall=1: pc_we=0, ifid_clr=1, all other _we=1, memwb_clr=0.
REQ-024 When neither stall is asserted: all _we=1 and both clr=0.
REQ-025 An IF completion in a cycle with mem_stall=1 SHALL NOT lose data; it is held in if_buf via if_hold.

Reset
REQ-026 When rst=0 at a clock edge, SHALL reset to: state=IDLE, bus_req=0, bus_we=0, bus_addr/bus_wdata=0, bus_be=0, if_buf=0, if_hold=0, counter=0, bus_err=0.
REQ-027 While rst=0, SHALL drive all _we=0, ifid_clr=1 and memwb_clr=1, overriding REQ-022..REQ-024.
REQ-028 Reset mid-access SHALL abandon the access without completion; no bus_err pulse and no if_hold.

Verification
REQ-029 Fetch only: if_req=1, if_addr=0x100, bus_ack 2 cycles after bus_req, bus_rdata=0x24020001 -> pc_we=0 and ifid_clr=1 until the ack cycle; if_rdata=0x24020001 in the ack cycle; pc_we=1 in the ack cycle.
REQ-030 Simultaneous: if_req=1 and mem_rd=1 (mem_addr=0x200) in IDLE -> MEM_BUSY first with bus_addr=0x200 and memwb_clr=1, exmem_we=0 until the ack; then IF_BUSY.
REQ-031 Store: mem_wr=1, mem_be=4'b0011, mem_wdata=0xABCD -> bus_we=1, bus_be=4'b0011, bus_wdata=0xABCD held until the ack; exmem_we=1 in the ack cycle.
REQ-032 Fetch completes while a load is pending -> if_hold=1, if_rdata stable from if_buf through the load, and no second fetch is issued.
REQ-033 No ack for 255 cycles in MEM_BUSY -> bus_err=1 for 1 cycle, mem_rdata=0, state=IDLE.
REQ-034 rst=0 asserted during IF_BUSY -> bus_req=0 next cycle, all _we=0 while in reset, and no bus_err pulse.
